diagv2_ecall_ctrl: RTL
======================

// Module: diagv2_ecall_ctrl
// PURPOSE
//  Hardware system-call sequencer for the diagv2 pipelined core. On an ECALL it freezes the core and decodes a7.
//  PRINT (a7=4): walks the NUL-terminated string at byte address a0 through a spare dmem read port,
//  streams each character out on a valid/ready byte port, then releases the core.
//  EXIT (a7=93): latches a0 as the exit code and holds the core halted until reset.
//  Any other a7 code flags an error and halts the core.
// PARAMETERS
//  DATA_W    64    dmem word width (= `DataBusBits); 8 bytes per line, little-endian
//  ADDR_W    12    dmem line-index width; line = a0[ADDR_W+2:3]
//  MAX_LEN   4096  maximum characters per PRINT before the error abort
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high
//  ecall_i       in   1       one-cycle pulse from core: ECALL retiring
//  a7_i          in   DATA_W  x17 value, valid with ecall_i
//  a0_i          in   DATA_W  x10 value, valid with ecall_i
//  stall_o       out  1       freeze core pipeline
//  dmem_req_o    out  1       read request, one cycle
//  dmem_addr_o   out  ADDR_W  line index for the read
//  dmem_rdata_i  in   DATA_W  read data
//  dmem_rvalid_i in   1       read data valid (any latency >= 1)
//  chr_valid_o   out  1       character available
//  chr_data_o    out  8       character
//  chr_ready_i   in   1       sink accepts the character
//  ecall_done_o  out  1       one-cycle pulse: PRINT finished
//  exit_o        out  1       sticky: EXIT taken
//  exit_code_o   out  DATA_W  latched a0 of the EXIT ecall
//  err_o         out  1       sticky: invalid a7 code, or MAX_LEN exceeded
// BEHAVIOUR
//  Reset: all outputs are 0; state is IDLE. Reset asserted mid-operation aborts immediately.
//    chr_valid_o may drop without a handshake only in this case.
//  stall_o = ecall_i | (state != IDLE): the core freezes in the same cycle as the ECALL.
//  States: IDLE, FETCH, WAIT, EMIT, DONE, HALT.
//  IDLE: on ecall_i, latch a7 and a0; set line = a0[ADDR_W+2:3], off = a0[2:0], cnt = 0. Then:
//    a7 = 93: exit_code_o <= a0; exit_o <= 1; go to HALT.
//    a7 = 4: go to FETCH.
//    else: err_o <= 1; go to HALT.
//  FETCH: dmem_req_o = 1 and dmem_addr_o = line for exactly one cycle; go to WAIT.
//  WAIT: hold until dmem_rvalid_i; latch dmem_rdata_i into wbuf; go to EMIT.
//  EMIT: b = wbuf[off*8 +: 8].
//    b == 0: go to DONE.
//    cnt == MAX_LEN: err_o <= 1; go to DONE.
//    else: chr_valid_o = 1, chr_data_o = b. On chr_ready_i: cnt++, off++.
//    off wraps 7 -> 0 with line++ and go to FETCH; otherwise stay in EMIT.
//  Handshake: chr_valid_o and chr_data_o stay stable until accepted. Same-cycle ready is allowed (1 char/cycle).
//  line wraps modulo 2^ADDR_W.
//  DONE: ecall_done_o = 1 for one cycle; go to IDLE, so stall_o drops the next cycle.
//  HALT: terminal. stall_o = 1; every ecall_i is ignored; leave only via reset.
//  ecall_i is ignored outside IDLE.
//  Latency with 1-cycle dmem, empty string: ecall at T, req at T+1, data at T+2, EMIT at T+3,
//    ecall_done at T+4, stall_o low at T+5.
// STRUCTURE
//  diagv2_const.vh:
//    `DataBusBits
//    SYS_PRINT = 4, SYS_EXIT = 93
//    state encodings for the ECALL sequencer
//  Single module with a one-hot FSM and an inline 8:1 byte-lane mux; no sub-module is needed.
// TESTING
//  EXIT: ecall with a7=93, a0=7 -> exit_o=1 and exit_code_o=7 next cycle.
//    stall_o stays 1; a later ecall_i has no effect.
//  PRINT aligned: a0=0x100, line 0x20 = 0x000A6948 -> chr stream 0x48, 0x69, 0x0A.
//    Then one ecall_done pulse; stall_o falls.
//  PRINT unaligned, crossing a line: a0=0x106, "ABCD\0" -> reads line 0x20 then line 0x21.
//    Emits 'A','B','C','D' in order, exactly two dmem requests.
//  Backpressure: chr_ready_i low for 5 cycles mid-string -> chr_valid_o and chr_data_o held stable.
//    No character lost or duplicated.
//  Invalid code: a7=7 -> err_o=1, no dmem request, no character, stall_o held.
//  Reset mid-PRINT, plus MAX_LEN=4 with a 6-char string:
//    reset -> all outputs 0 within the reset; a fresh PRINT then works.
//    MAX_LEN=4 -> 4 chars emitted, err_o=1, ecall_done pulse.

Source files
------------

// File: rtl/diagv2_ecall_ctrl_pkg.sv
// Shared constants, FSM state encoding and the a7 system-call decoder for the
// diagv2 ECALL sequencer.
package diagv2_ecall_ctrl_pkg;

    localparam logic [63:0] SYS_PRINT = 64'd4;
    localparam logic [63:0] SYS_EXIT  = 64'd93;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_FETCH = 6'b000010,
        ST_WAIT  = 6'b000100,
        ST_EMIT  = 6'b001000,
        ST_DONE  = 6'b010000,
        ST_HALT  = 6'b100000
    } state_e;

    typedef enum logic [1:0] {
        SYS_K_PRINT = 2'd0,
        SYS_K_EXIT  = 2'd1,
        SYS_K_BAD   = 2'd2
    } sys_kind_e;

    function automatic sys_kind_e decode_a7(input logic [63:0] a7);
        sys_kind_e kind;
        if (a7 == SYS_EXIT) begin
            kind = SYS_K_EXIT;
        end else if (a7 == SYS_PRINT) begin
            kind = SYS_K_PRINT;
        end else begin
            kind = SYS_K_BAD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/diagv2_ecall_ctrl.sv
// ECALL sequencer: freezes the core, then services PRINT (byte stream out of dmem),
// EXIT (latched exit code, permanent halt) or flags an unknown call.
module diagv2_ecall_ctrl
    import diagv2_ecall_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned MAX_LEN = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ecall_i,
    input  logic [DATA_W-1:0] a7_i,
    input  logic [DATA_W-1:0] a0_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_rvalid_i,
    output logic              chr_valid_o,
    output logic [7:0]        chr_data_o,
    input  logic              chr_ready_i,
    output logic              ecall_done_o,
    output logic              exit_o,
    output logic [DATA_W-1:0] exit_code_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   line_q;
    logic [2:0]          off_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   wbuf_q;
    logic                exit_q;
    logic                err_q;
    logic [DATA_W-1:0]   exit_code_q;

    logic [7:0]          byte_cur;
    logic                byte_nul;
    logic                len_hit;
    logic                emit_ok;
    logic                accept;
    logic                ecall_take;
    sys_kind_e           kind;

    // Byte lane selected by the in-line offset; little-endian within the word.
    assign byte_cur   = wbuf_q[{off_q, 3'b000} +: 8];
    assign byte_nul   = (byte_cur == 8'h00);
    assign len_hit    = (cnt_q == CNT_W'(MAX_LEN));
    assign emit_ok    = (state_q == ST_EMIT) && !byte_nul && !len_hit;
    assign accept     = emit_ok && chr_ready_i;
    assign ecall_take = (state_q == ST_IDLE) && ecall_i;
    assign kind       = decode_a7(a7_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ecall_i) begin
                    state_d = (kind == SYS_K_PRINT) ? ST_FETCH : ST_HALT;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (byte_nul || len_hit) begin
                    state_d = ST_DONE;
                end else if (accept && (off_q == 3'd7)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o      = ecall_i | (state_q != ST_IDLE);
        dmem_req_o   = (state_q == ST_FETCH);
        dmem_addr_o  = '0;
        if (state_q == ST_FETCH) begin
            dmem_addr_o = line_q;
        end
        chr_valid_o  = emit_ok;
        chr_data_o   = emit_ok ? byte_cur : 8'h00;
        ecall_done_o = (state_q == ST_DONE);
        exit_o       = exit_q;
        exit_code_o  = exit_code_q;
        err_o        = err_q;
    end

    // Sticky status: only reset clears exit/err and the exit code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exit_q      <= 1'b0;
            err_q       <= 1'b0;
            exit_code_q <= '0;
        end else begin
            if (ecall_take) begin
                case (kind)
                    SYS_K_EXIT: begin
                        exit_q      <= 1'b1;
                        exit_code_q <= a0_i;
                    end
                    SYS_K_BAD: err_q <= 1'b1;
                    default: ;
                endcase
            end
            if ((state_q == ST_EMIT) && !byte_nul && len_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // String walk pointers; reloaded on every accepted ECALL, so no reset needed.
    always_ff @(posedge clk) begin
        if (ecall_take) begin
            line_q <= a0_i[ADDR_W+2:3];
            off_q  <= a0_i[2:0];
            cnt_q  <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            off_q <= off_q + 3'd1;
            if (off_q == 3'd7) begin
                line_q <= line_q + ADDR_W'(1);
            end
        end
        if ((state_q == ST_WAIT) && dmem_rvalid_i) begin
            wbuf_q <= dmem_rdata_i;
        end
    end

endmodule
